// File: rtl/addsub_rr_sched.sv
// rtl/addsub_rr_sched.sv - round-robin scheduler sharing one add/sub unit among requesters
module addsub_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 8,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_mode,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic                     alu_mode,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic                     alu_carry,
  input  logic                     alu_borrow,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_flag,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic [IDW-1:0]   rr_ptr;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_mode;
  logic [IDW-1:0]   op_id;

  logic             found;
  logic [IDW-1:0]   winner;

  // Unpacked views of the packed operand buses so the winner can index them directly.
  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
    assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
  end

  // Search for the first valid requester starting at rr_ptr, wrapping around.
  always_comb begin : p_arb
    logic [IDW-1:0] cand;
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Grant only the winner, and only while idle.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state == S_IDLE) && found && (winner == IDW'(i));
    end
  end

  // The shared unit sees the latched operation, so it only changes on a new grant.
  assign alu_a    = op_a;
  assign alu_b    = op_b;
  assign alu_mode = op_mode;
  assign busy     = (state != S_IDLE);

  // Control FSM, operation latch, response capture and completion counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_mode   <= 1'b0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_flag  <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            op_a    <= a_arr[winner];
            op_b    <= b_arr[winner];
            op_mode <= req_mode[winner];
            op_id   <= winner;
            rr_ptr  <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data  <= alu_out;
          rsp_flag  <= op_mode ? alu_borrow : alu_carry;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (op_count != '1) begin
              op_count <= op_count + CNT_W'(1);
            end
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_rr_sched.sv
// tb/tb_addsub_rr_sched.sv - self-checking bench for addsub_rr_sched
module tb_addsub_rr_sched;

  localparam int NR  = 4;
  localparam int W   = 4;
  localparam int CW  = 8;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*W-1:0] req_a = '0;
  logic [NR*W-1:0] req_b = '0;
  logic [NR-1:0]   req_mode = '0;
  logic [NR-1:0]   req_ready;
  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  logic            alu_mode;
  logic [W-1:0]    alu_out;
  logic            alu_carry;
  logic            alu_borrow;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [IDW-1:0]  rsp_id;
  logic [W-1:0]    rsp_data;
  logic            rsp_flag;
  logic            busy;
  logic [CW-1:0]   op_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  addsub_rr_sched #(.NUM_REQ(NR), .WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
    .req_ready(req_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_borrow(alu_borrow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flag(rsp_flag),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared adder/subtractor unit
  logic [W:0] unit_sum;
  always_comb begin
    unit_sum   = {1'b0, alu_a} + {1'b0, alu_b};
    alu_out    = alu_mode ? (alu_a - alu_b) : unit_sum[W-1:0];
    alu_carry  = !alu_mode && unit_sum[W];
    alu_borrow = alu_mode && (alu_a < alu_b);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference result from plain integer arithmetic
  function automatic void ref_calc(input int a, input int b, input bit m,
                                   output logic [W-1:0] d, output logic f);
    int r;
    r = m ? (a - b) : (a + b);
    d = W'(r & ((1 << W) - 1));
    f = m ? (a < b) : ((a + b) >= (1 << W));
  endfunction

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_mode  = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  // Issue one op from requester id, hold rsp_ready low for hold cycles, then accept
  task automatic send_op(input int id, input int a, input int b, input bit m, input int hold,
                         output logic [IDW-1:0] gid, output logic [W-1:0] gd,
                         output logic gf, output int lat);
    int n;
    int hs;
    req_valid         = '0;
    req_valid[id]     = 1'b1;
    req_a[id*W +: W]  = W'(a);
    req_b[id*W +: W]  = W'(b);
    req_mode[id]      = m;
    rsp_ready         = 1'b0;
    gid = '0; gd = '0; gf = 1'b0; lat = -1;
    #1;
    n = 0;
    while (!req_ready[id] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready[id]) begin
      tests++; fails++;
      $display("FAIL grant_timeout: id=%0d req_ready=%b required grant", id, req_ready);
      req_valid = '0;
      return;
    end
    hs = cyc;
    @(posedge clk); #1;
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    if (!rsp_valid) begin
      tests++; fails++;
      $display("FAIL rsp_timeout: id=%0d rsp_valid=0 required 1", id);
      return;
    end
    lat = cyc - hs;
    gid = rsp_id; gd = rsp_data; gf = rsp_flag;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    #3;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (op_count !== '0) begin fails++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
    tests++; if (req_ready !== '0) begin fails++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    tests++; if ({alu_a, alu_b, alu_mode} !== '0) begin fails++; $display("FAIL reset_alu: got a=%0d b=%0d m=%b want 0", alu_a, alu_b, alu_mode); end
    tests++; if ({rsp_id, rsp_data, rsp_flag} !== '0) begin fails++; $display("FAIL reset_rsp_regs: got id=%0d d=%0d f=%b want 0", rsp_id, rsp_data, rsp_flag); end
    apply_reset();
  endtask

  task automatic test_directed();
    logic [IDW-1:0] gid; logic [W-1:0] gd; logic gf; int lat;
    apply_reset();
    send_op(0, 5, 3, 1'b0, 0, gid, gd, gf, lat);
    tests++; if (gid !== 2'd0 || gd !== 4'd8 || gf !== 1'b0) begin fails++; $display("FAIL add_5_3: got id=%0d d=%0d f=%b want 0/8/0", gid, gd, gf); end
    tests++; if (lat != 2) begin fails++; $display("FAIL latency: got %0d want 2", lat); end
    tests++; if (op_count !== 8'd1) begin fails++; $display("FAIL op_count_first: got %0d want 1", op_count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_after_accept: got %b want 0", busy); end
    send_op(2, 9, 8, 1'b0, 0, gid, gd, gf, lat);
    tests++; if (gid !== 2'd2 || gd !== 4'd1 || gf !== 1'b1) begin fails++; $display("FAIL add_carry: got id=%0d d=%0d f=%b want 2/1/1", gid, gd, gf); end
    send_op(1, 3, 5, 1'b1, 0, gid, gd, gf, lat);
    tests++; if (gid !== 2'd1 || gd !== 4'd14 || gf !== 1'b1) begin fails++; $display("FAIL sub_borrow: got id=%0d d=%0d f=%b want 1/14/1", gid, gd, gf); end
    repeat (3) begin @(posedge clk); #1; end
    tests++; if (alu_a !== 4'd3 || alu_b !== 4'd5 || alu_mode !== 1'b1) begin fails++; $display("FAIL alu_hold_idle: got a=%0d b=%0d m=%b want 3/5/1", alu_a, alu_b, alu_mode); end
  endtask

  task automatic test_round_robin();
    int a_v[NR]; int b_v[NR]; bit m_v[NR];
    int gids[$]; int gcyc[$]; int pend[$];
    int n; int w; int e;
    logic [W-1:0] ed; logic ef;
    apply_reset();
    for (int i = 0; i < NR; i++) begin
      a_v[i] = $urandom_range(0, 15); b_v[i] = $urandom_range(0, 15); m_v[i] = 1'($urandom_range(0, 1));
      req_a[i*W +: W] = W'(a_v[i]); req_b[i*W +: W] = W'(b_v[i]); req_mode[i] = m_v[i];
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    n = 0;
    while (gids.size() < 5 && n < 40) begin
      if ((req_valid & req_ready) != '0) begin
        w = 0;
        for (int i = 0; i < NR; i++) if (req_ready[i]) w = i;
        tests++; if ($countones(req_ready) != 1) begin fails++; $display("FAIL rr_onehot: got %b want one-hot", req_ready); end
        gids.push_back(w); gcyc.push_back(cyc); pend.push_back(w);
      end
      if (rsp_valid && pend.size() > 0) begin
        e = pend.pop_front();
        ref_calc(a_v[e], b_v[e], m_v[e], ed, ef);
        tests++; if (rsp_id !== IDW'(e) || rsp_data !== ed || rsp_flag !== ef) begin fails++; $display("FAIL rr_rsp: got id=%0d d=%0d f=%b want %0d/%0d/%b", rsp_id, rsp_data, rsp_flag, e, ed, ef); end
      end
      @(posedge clk); #1; n++;
    end
    tests++; if (gids.size() != 5) begin fails++; $display("FAIL rr_grant_count: got %0d want 5", gids.size()); end
    for (int k = 0; k < gids.size(); k++) begin
      tests++; if (gids[k] != k % NR) begin fails++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, gids[k], k % NR); end
      if (k > 0) begin
        tests++; if (gcyc[k] - gcyc[k-1] != 3) begin fails++; $display("FAIL rr_interval[%0d]: got %0d want 3", k, gcyc[k] - gcyc[k-1]); end
      end
    end
    req_valid = '0;
    repeat (4) begin @(posedge clk); #1; end
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [IDW-1:0] sid; logic [W-1:0] sd; logic sf;
    int n;
    apply_reset();
    req_valid = 4'b0001; req_a[3:0] = 4'd7; req_b[3:0] = 4'd2; req_mode[0] = 1'b1;
    #1;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 4'd5 || rsp_flag !== 1'b0) begin fails++; $display("FAIL bp_first_rsp: got v=%b id=%0d d=%0d f=%b want 1/0/5/0", rsp_valid, rsp_id, rsp_data, rsp_flag); end
    sid = rsp_id; sd = rsp_data; sf = rsp_flag;
    req_valid = 4'b0010;
    for (n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      tests++; if (rsp_valid !== 1'b1 || rsp_id !== sid || rsp_data !== sd || rsp_flag !== sf) begin fails++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d d=%0d f=%b want stable", n, rsp_valid, rsp_id, rsp_data, rsp_flag); end
      tests++; if (req_ready !== '0 || busy !== 1'b1) begin fails++; $display("FAIL bp_ready_busy[%0d]: got ready=%b busy=%b want 0/1", n, req_ready, busy); end
    end
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL bp_release: got v=%b busy=%b want 0/0", rsp_valid, busy); end
    tests++; if (op_count !== 8'd1) begin fails++; $display("FAIL bp_count: got %0d want 1", op_count); end
    tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL dropped_valid_skip: got %b want 1000", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) begin @(posedge clk); #1; end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_exec();
    apply_reset();
    req_valid = 4'b0100; req_a[11:8] = 4'd6; req_b[11:8] = 4'd1; req_mode[2] = 1'b0;
    #1;
    @(posedge clk); #1;
    req_valid = '0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rexec_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== '0 || alu_a !== '0) begin fails++; $display("FAIL rexec_abort: got v=%b busy=%b cnt=%0d alu_a=%0d want 0", rsp_valid, busy, op_count, alu_a); end
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rexec_no_rsp: got %b want 0", rsp_valid); end
    rst_n = 1'b1;
    req_valid = '1;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL rexec_ptr: got %b want 0001", req_ready); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) begin @(posedge clk); #1; end
    rsp_ready = 1'b0;
  endtask

  task automatic test_sweep();
    logic [IDW-1:0] gid; logic [W-1:0] gd; logic gf; int lat;
    logic [W-1:0] ed; logic ef;
    int id; int k; int ecnt;
    apply_reset();
    k = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int m = 0; m < 2; m++) begin
          id = $urandom_range(0, NR - 1);
          send_op(id, a, b, 1'(m), $urandom_range(0, 2), gid, gd, gf, lat);
          ref_calc(a, b, 1'(m), ed, ef);
          k++;
          ecnt = (k > 255) ? 255 : k;
          tests++; if (gid !== IDW'(id) || gd !== ed || gf !== ef) begin fails++; $display("FAIL sweep a=%0d b=%0d m=%0d: got id=%0d d=%0d f=%b want %0d/%0d/%b", a, b, m, gid, gd, gf, id, ed, ef); end
          tests++; if (op_count !== CW'(ecnt)) begin fails++; $display("FAIL sweep_count k=%0d: got %0d want %0d", k, op_count, ecnt); end
        end
      end
    end
    tests++; if (op_count !== 8'd255) begin fails++; $display("FAIL count_saturate: got %0d want 255", op_count); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_round_robin();
    test_backpressure();
    test_reset_exec();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
